alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer: sequences one command at a time through an external 8-bit ALU
// into an accumulator. Define ALU_CMD_ISSUER_MUL_EN to add the shift-add multiply.
module alu_cmd_issuer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_b,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_res,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_cf,
  input  logic       alu_of,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic       rsp_err
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(4'hF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
`ifdef ALU_CMD_ISSUER_MUL_EN
    S_MUL   = 2'd3,
`endif
    S_RESP  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [FLAG_W-1:0]   flags;
  logic                err_r;

`ifdef ALU_CMD_ISSUER_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(4'hB);

  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   p;
  logic [2:0]          mul_cnt;
  logic [DATA_W-1:0]   p_next;

  // Partial product after the current step: accumulate only where the multiplier bit is set
  assign p_next = b_r[mul_cnt] ? alu_res : p;
`endif

  assign rsp_data  = acc;
  assign rsp_flags = flags;
  assign rsp_err   = err_r;

  // ALU operands are registered one edge ahead so they are stable for the whole ISSUE/MUL cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= DATA_W'(0);
      flags     <= FLAG_W'(0);
      err_r     <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_op    <= OP_W'(0);
      alu_a     <= DATA_W'(0);
      alu_b     <= DATA_W'(0);
`ifdef ALU_CMD_ISSUER_MUL_EN
      b_r       <= DATA_W'(0);
      p         <= DATA_W'(0);
      mul_cnt   <= 3'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            err_r     <= 1'b0;
`ifdef ALU_CMD_ISSUER_MUL_EN
            b_r       <= cmd_b;
`endif
            if (cmd_op <= OP_SLTU) begin
              state  <= S_ISSUE;
              alu_op <= cmd_op;
              alu_a  <= acc;
              alu_b  <= cmd_b;
`ifdef ALU_CMD_ISSUER_MUL_EN
            end else if (cmd_op == OP_MUL) begin
              state   <= S_MUL;
              mul_cnt <= 3'd0;
              p       <= DATA_W'(0);
              alu_op  <= OP_ADD;
              alu_a   <= DATA_W'(0);
              alu_b   <= acc;
`endif
            end else if (cmd_op == OP_LOAD) begin
              state <= S_RESP;
              acc   <= cmd_b;
              flags <= {cmd_b == DATA_W'(0), cmd_b[DATA_W-1], 2'b00};
            end else begin
              state <= S_RESP;
              err_r <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          acc    <= alu_res;
          flags  <= {alu_zf, alu_sf, alu_cf, alu_of};
          alu_op <= OP_W'(0);
          alu_a  <= DATA_W'(0);
          alu_b  <= DATA_W'(0);
          state  <= S_RESP;
        end

`ifdef ALU_CMD_ISSUER_MUL_EN
        S_MUL: begin
          p       <= p_next;
          mul_cnt <= mul_cnt + 3'd1;
          if (mul_cnt == 3'd7) begin
            acc    <= p_next;
            flags  <= {p_next == DATA_W'(0), p_next[DATA_W-1], 2'b00};
            alu_op <= OP_W'(0);
            alu_a  <= DATA_W'(0);
            alu_b  <= DATA_W'(0);
            state  <= S_RESP;
          end else begin
            alu_a <= p_next;
            alu_b <= acc << (mul_cnt + 3'd1);
          end
        end
`endif

        // First RESP cycle raises rsp_valid; handshake is taken only once it is visible
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: behavioural ALU, accumulator reference model,
// directed and random commands, reset corner cases.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_b;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic       alu_zf, alu_sf, alu_cf, alu_of;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_acc;
  logic [3:0] m_flags;

  alu_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: returns {ZF, SF, CF, OF, result}
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    r = 8'd0;
    w = 9'd0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = a ^ b;
      4'd6: r = a << b[2:0];
      4'd7: r = a >> b[2:0];
      4'd8: r = 8'($signed(a) >>> b[2:0]);
      4'd9: r = {7'd0, $signed(a) < $signed(b)};
      4'd10: r = {7'd0, a < b};
      default: r = 8'd0;
    endcase
    return {r == 8'd0, r[7], c, o, r};
  endfunction

  logic [11:0] alu_out;
  always_comb alu_out = alu_f(alu_op, alu_a, alu_b);
  assign {alu_zf, alu_sf, alu_cf, alu_of, alu_res} = alu_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a command at a negedge; return at the negedge following the accept edge
  task automatic accept(input logic [3:0] op, input logic [7:0] b);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_b     = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] b, input int bp);
    int         exp_lat, lat;
    logic       exp_err;
    logic [7:0] exp_acc;
    logic [3:0] exp_flags;
    logic [11:0] fr;
    logic [7:0] old_acc;
    logic [15:0] prod;
    logic       mul_en;
`ifdef ALU_CMD_ISSUER_MUL_EN
    mul_en = 1'b1;
`else
    mul_en = 1'b0;
`endif
    old_acc   = m_acc;
    exp_err   = 1'b0;
    exp_acc   = m_acc;
    exp_flags = m_flags;
    if (op <= 4'd10) begin
      fr = alu_f(op, m_acc, b);
      exp_acc = fr[7:0];
      exp_flags = fr[11:8];
      exp_lat = 2;
    end else if (op == 4'hF) begin
      exp_acc = b;
      exp_flags = {b == 8'd0, b[7], 2'b00};
      exp_lat = 1;
    end else if (op == 4'hB && mul_en) begin
      prod = 16'(m_acc) * 16'(b);
      exp_acc = prod[7:0];
      exp_flags = {exp_acc == 8'd0, exp_acc[7], 2'b00};
      exp_lat = 9;
    end else begin
      exp_err = 1'b1;
      exp_lat = 1;
    end

    accept(op, b);
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    if (op <= 4'd10) begin
      chk("issue_op", 32'(alu_op), 32'(op));
      chk("issue_a", 32'(alu_a), 32'(old_acc));
      chk("issue_b", 32'(alu_b), 32'(b));
    end else if (exp_lat == 9) begin
      chk("mul0_a", 32'(alu_a), 32'd0);
      chk("mul0_b", 32'(alu_b), 32'(old_acc));
    end else begin
      chk("idle_alu_op", 32'(alu_op), 32'd0);
    end

    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_data", 32'(rsp_data), 32'(exp_acc));
    chk("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("resp_alu_op", 32'(alu_op), 32'd0);

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(exp_acc));
      chk("bp_flags", 32'(rsp_flags), 32'(exp_flags));
      chk("bp_ready", 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(cmd_ready), 32'd1);
    m_acc   = exp_acc;
    m_flags = exp_flags;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'd0);
    m_acc   = 8'd0;
    m_flags = 4'd0;
  endtask

  task automatic quiet_window(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_b = 8'd0;
    rsp_ready = 1'b0;
    m_acc = 8'd0;
    m_flags = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);

    // LOAD 7F then ADD 1: signed overflow into 0x80
    run_cmd(4'hF, 8'h7F, 0);
    run_cmd(4'h0, 8'h01, 0);
    chk("add_ovf_data", 32'(rsp_data), 32'h80);
    chk("add_ovf_flags", 32'(rsp_flags), 32'b0101);

    run_cmd(4'hF, 8'h05, 0);
    run_cmd(4'h1, 8'h05, 0);
    chk("sub_zero_data", 32'(rsp_data), 32'h00);
    chk("sub_zero_zf", 32'(rsp_flags[3]), 32'd1);
    run_cmd(4'hA, 8'h01, 0);
    chk("sltu_data", 32'(rsp_data), 32'h01);

    run_cmd(4'h3, 8'h10, 5);

    run_cmd(4'hF, 8'h33, 0);
    run_cmd(4'hD, 8'h00, 0);
    chk("illegal_err", 32'(rsp_err), 32'd1);
    chk("illegal_data", 32'(rsp_data), 32'h33);

    run_cmd(4'hF, 8'h0D, 0);
    run_cmd(4'hB, 8'h0B, 0);
`ifdef ALU_CMD_ISSUER_MUL_EN
    chk("mul_data", 32'(rsp_data), 32'h8F);
    chk("mul_err", 32'(rsp_err), 32'd0);
`else
    chk("mul_off_data", 32'(rsp_data), 32'h0D);
    chk("mul_off_err", 32'(rsp_err), 32'd1);
`endif

    // Reset in the middle of a long command discards it
    run_cmd(4'hF, 8'h0D, 0);
`ifdef ALU_CMD_ISSUER_MUL_EN
    accept(4'hB, 8'h0B);
    repeat (3) @(negedge clk);
`else
    accept(4'h0, 8'h22);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_mid");
    quiet_window("rst_mid_no_rsp", 12);

    // Reset while the response is being offered
    run_cmd(4'hF, 8'h44, 0);
    accept(4'h0, 8'h01);
    repeat (2) @(negedge clk);
    chk("resp_before_rst", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_resp");

    // Reset wins over a command offered in the same cycle
    run_cmd(4'hF, 8'h55, 0);
    cmd_valid = 1'b1;
    cmd_op = 4'hF;
    cmd_b = 8'hAA;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    check_reset_state("rst_prio");
    quiet_window("rst_prio_no_rsp", 4);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] rop;
      logic [7:0] rb;
      rop = 4'($urandom_range(15, 0));
      rb  = 8'($urandom);
      run_cmd(rop, rb, int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
